// File: rtl/hx711_multi_reader_if.sv
// Pin and register-side bundle for the multi-channel HX711 reader.
// The slave modport is the reader itself; master is whoever drives the load cells and controls.
interface hx711_multi_reader_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]    dout;
    logic                 pd_sck;
    logic [1:0]           gain_sel;
    logic                 tare_req;
    logic                 power_down;
    logic [NUM_CH*24-1:0] value_raw;
    logic [NUM_CH*32-1:0] value_net;
    logic [NUM_CH*32-1:0] value_scaled;
    logic                 sample_valid;
    logic                 busy;
    logic                 timeout;

    modport master (
        output dout, gain_sel, tare_req, power_down,
        input  pd_sck, value_raw, value_net, value_scaled, sample_valid, busy, timeout
    );

    modport slave (
        input  dout, gain_sel, tare_req, power_down,
        output pd_sck, value_raw, value_net, value_scaled, sample_valid, busy, timeout
    );
endinterface

// File: rtl/hx711_multi_reader.sv
// Reads NUM_CH HX711 converters over one shared pd_sck, averaging, taring
// and scaling each channel, with power-down handling and a no-data timeout.
module hx711_multi_reader #(
    parameter int NUM_CH      = 2,
    parameter int HALF_PERIOD = 32,
    parameter int SCALE       = 173,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                 clk_50,
    input  logic                 rst_n,
    hx711_multi_reader_if.slave  bus
);
    localparam int HP_W = $clog2(HALF_PERIOD) + 1;
    localparam logic [HP_W-1:0]   HALF_LAST = HP_W'(HALF_PERIOD - 1);
    localparam logic [6:0]        AVG_LAST  = 7'((1 << AVG_LOG2) - 1);
    localparam logic [31:0]       IDLE_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic signed [31:0] SCALE_W  = 32'(SCALE);

    typedef enum logic [1:0] {IDLE, SHIFT, ACCUM, PWRDN} state_t;

    state_t              state;
    logic [4:0]          pulse_cnt;
    logic [4:0]          pulse_num;
    logic [HP_W-1:0]     half_cnt;
    logic [31:0]         idle_cnt;
    logic [6:0]          count;
    logic                tare_pend;
    logic                wake;
    logic [23:0]         shreg    [NUM_CH];
    logic signed [31:0]  acc      [NUM_CH];
    logic signed [31:0]  tare     [NUM_CH];
    logic signed [31:0]  acc_next [NUM_CH];
    logic signed [31:0]  avg      [NUM_CH];
    logic signed [31:0]  net      [NUM_CH];
    logic signed [31:0]  scaled   [NUM_CH];
    logic [4:0]          gain_pulses;
    logic                avg_done;

    // Only the low 32 bits of the product are kept, so a 32x32 multiply suffices.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_next[i] = acc[i] + $signed({{8{shreg[i][23]}}, shreg[i]});
            avg[i]      = acc_next[i] >>> AVG_LOG2;
            net[i]      = tare_pend ? 32'sd0 : avg[i] - tare[i];
            scaled[i]   = net[i] * SCALE_W;
        end
        avg_done = (count == AVG_LAST);
        case (bus.gain_sel)
            2'd1:    gain_pulses = 5'd26;
            2'd2:    gain_pulses = 5'd27;
            default: gain_pulses = 5'd25;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.pd_sck       <= 1'b0;
            bus.value_raw    <= '0;
            bus.value_net    <= '0;
            bus.value_scaled <= '0;
            bus.sample_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.timeout      <= 1'b0;
            pulse_cnt        <= '0;
            pulse_num        <= 5'd25;
            half_cnt         <= '0;
            idle_cnt         <= '0;
            count            <= '0;
            tare_pend        <= 1'b0;
            wake             <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shreg[i] <= '0;
                acc[i]   <= '0;
                tare[i]  <= '0;
            end
        end else begin
            bus.sample_valid <= 1'b0;
            if (bus.tare_req) begin
                tare_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    bus.pd_sck <= 1'b0;
                    if (bus.power_down) begin
                        state      <= PWRDN;
                        bus.pd_sck <= 1'b1;
                        idle_cnt   <= '0;
                    end else if (bus.dout == '0) begin
                        state      <= SHIFT;
                        bus.busy   <= 1'b1;
                        bus.pd_sck <= 1'b1;
                        pulse_num  <= wake ? 5'd25 : gain_pulses;
                        wake       <= 1'b0;
                        pulse_cnt  <= '0;
                        half_cnt   <= '0;
                        idle_cnt   <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        bus.timeout <= 1'b1;
                        idle_cnt    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                SHIFT: begin
                    if (bus.power_down) begin
                        state      <= PWRDN;
                        bus.pd_sck <= 1'b1;
                        bus.busy   <= 1'b0;
                    end else if (bus.pd_sck) begin
                        if (half_cnt == HALF_LAST) begin
                            half_cnt   <= '0;
                            bus.pd_sck <= 1'b0;
                            if (pulse_cnt < 5'd24) begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    shreg[i] <= {shreg[i][22:0], bus.dout[i]};
                                end
                            end
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end else begin
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= '0;
                            if (pulse_cnt == pulse_num - 5'd1) begin
                                state <= ACCUM;
                            end else begin
                                pulse_cnt  <= pulse_cnt + 5'd1;
                                bus.pd_sck <= 1'b1;
                            end
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    bus.busy <= 1'b0;
                    if (bus.power_down) begin
                        state      <= PWRDN;
                        bus.pd_sck <= 1'b1;
                    end else begin
                        state <= IDLE;
                        for (int i = 0; i < NUM_CH; i++) begin
                            bus.value_raw[i*24 +: 24] <= shreg[i];
                        end
                        if (avg_done) begin
                            bus.sample_valid <= 1'b1;
                            bus.timeout      <= 1'b0;
                            count            <= '0;
                            // A request arriving in this very cycle stays pending for the next average.
                            tare_pend        <= bus.tare_req;
                            for (int i = 0; i < NUM_CH; i++) begin
                                acc[i]                       <= '0;
                                bus.value_net[i*32 +: 32]    <= net[i];
                                bus.value_scaled[i*32 +: 32] <= scaled[i];
                                if (tare_pend) begin
                                    tare[i] <= avg[i];
                                end
                            end
                        end else begin
                            count <= count + 7'd1;
                            for (int i = 0; i < NUM_CH; i++) begin
                                acc[i] <= acc_next[i];
                            end
                        end
                    end
                end
                PWRDN: begin
                    count    <= '0;
                    idle_cnt <= '0;
                    wake     <= 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc[i] <= '0;
                    end
                    if (bus.power_down) begin
                        bus.pd_sck <= 1'b1;
                    end else begin
                        bus.pd_sck <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.pd_sck <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hx711_multi_reader.sv
// Directed bench for hx711_multi_reader: two instances (no averaging with a
// short timeout, and 4-sample averaging) fed by a behavioural HX711 model.
module tb_hx711_multi_reader;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  dout_v  [2];
    logic [1:0]  gain_v  [2];
    logic        tare_v  [2];
    logic        pwr_v   [2];
    logic        pd_v    [2];
    logic        sv_v    [2];
    logic        busy_v  [2];
    logic        to_v    [2];
    logic [47:0] raw_v   [2];
    logic [63:0] net_v   [2];
    logic [63:0] scl_v   [2];

    always #5 clk = ~clk;

    hx711_multi_reader_if #(.NUM_CH(2)) if_a ();
    hx711_multi_reader_if #(.NUM_CH(2)) if_b ();

    assign if_a.dout       = dout_v[0];
    assign if_a.gain_sel   = gain_v[0];
    assign if_a.tare_req   = tare_v[0];
    assign if_a.power_down = pwr_v[0];
    assign if_b.dout       = dout_v[1];
    assign if_b.gain_sel   = gain_v[1];
    assign if_b.tare_req   = tare_v[1];
    assign if_b.power_down = pwr_v[1];

    assign pd_v[0]   = if_a.pd_sck;
    assign sv_v[0]   = if_a.sample_valid;
    assign busy_v[0] = if_a.busy;
    assign to_v[0]   = if_a.timeout;
    assign raw_v[0]  = if_a.value_raw;
    assign net_v[0]  = if_a.value_net;
    assign scl_v[0]  = if_a.value_scaled;
    assign pd_v[1]   = if_b.pd_sck;
    assign sv_v[1]   = if_b.sample_valid;
    assign busy_v[1] = if_b.busy;
    assign to_v[1]   = if_b.timeout;
    assign raw_v[1]  = if_b.value_raw;
    assign net_v[1]  = if_b.value_net;
    assign scl_v[1]  = if_b.value_scaled;

    hx711_multi_reader #(
        .NUM_CH(2), .HALF_PERIOD(32), .SCALE(173), .AVG_LOG2(0), .TIMEOUT_CYC(1000)
    ) dut_a (
        .clk_50(clk), .rst_n(rst_n), .bus(if_a.slave)
    );

    hx711_multi_reader #(
        .NUM_CH(2), .HALF_PERIOD(4), .SCALE(173), .AVG_LOG2(2), .TIMEOUT_CYC(50000000)
    ) dut_b (
        .clk_50(clk), .rst_n(rst_n), .bus(if_b.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Plays one HX711 conversion on instance k: signals ready, presents bits on
    // pd_sck rising edges, and optionally aborts after the fall of pulse 10
    // (mode 1: power_down, mode 2: reset).
    task automatic applyStimulus(input int k, input logic [23:0] d0, input logic [23:0] d1,
                                 input int abort_mode, output int pulses, output int valids,
                                 output bit done, output logic to_end);
        logic prev;
        bit   seen_busy;
        pulses    = 0;
        valids    = 0;
        done      = 1'b0;
        seen_busy = 1'b0;
        to_end    = 1'bx;
        prev      = pd_v[k];
        dout_v[k] = 2'b00;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if (pd_v[k] && !prev) begin
                pulses++;
                if (pulses <= 24) dout_v[k] = {d1[24-pulses], d0[24-pulses]};
                else              dout_v[k] = 2'b11;
            end
            if (!pd_v[k] && prev && pulses == 10 && abort_mode != 0) begin
                dout_v[k] = 2'b11;
                if (abort_mode == 1) pwr_v[k] = 1'b1;
                else                 rst_n    = 1'b0;
                return;
            end
            prev = pd_v[k];
            if (sv_v[k]) valids++;
            if (busy_v[k]) seen_busy = 1'b1;
            else if (seen_busy) begin
                done   = 1'b1;
                to_end = to_v[k];
            end
        end
        if (!done) checkOutput("conversion_done", 64'(done), 64'd1);
        repeat (2) begin
            @(negedge clk);
            if (sv_v[k]) valids++;
        end
    endtask

    int   pulses, valids, busy_cnt, bad_cnt;
    bit   done;
    logic to_end;
    logic [23:0] avg_ch0 [4] = '{24'd100, 24'd102, 24'd104, 24'd106};
    logic [23:0] avg_ch1 [4] = '{24'hFFFFFD, 24'hFFFFFC, 24'hFFFFFC, 24'hFFFFFC};

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dout_v[k] = 2'b11;
            gain_v[k] = 2'd0;
            tare_v[k] = 1'b0;
            pwr_v[k]  = 1'b0;
        end
        waitCycles(3);
        checkOutput("rst_pd_sck", 64'(pd_v[0]), 64'd0);
        checkOutput("rst_raw", 64'(raw_v[0]), 64'd0);
        checkOutput("rst_net", net_v[0], 64'd0);
        checkOutput("rst_scaled", scl_v[0], 64'd0);
        checkOutput("rst_flags", {61'd0, sv_v[0], busy_v[0], to_v[0]}, 64'd0);
        rst_n = 1'b1;
        waitCycles(2);

        // Basic conversion, A/128
        applyStimulus(0, 24'h000100, 24'hFFFF00, 0, pulses, valids, done, to_end);
        checkOutput("t1_pulses", 64'(pulses), 64'd25);
        checkOutput("t1_valids", 64'(valids), 64'd1);
        checkOutput("t1_raw", 64'(raw_v[0]), 64'h0000_FFFF00_000100);
        checkOutput("t1_net", net_v[0], 64'hFFFFFF00_00000100);
        checkOutput("t1_scaled", scl_v[0], 64'hFFFF5300_0000AD00);

        // Gain selection sets the pulse count
        gain_v[0] = 2'd2;
        applyStimulus(0, 24'h123456, 24'h800000, 0, pulses, valids, done, to_end);
        checkOutput("t2_pulses27", 64'(pulses), 64'd27);
        checkOutput("t2_raw27", 64'(raw_v[0]), 64'h0000_800000_123456);
        gain_v[0] = 2'd1;
        applyStimulus(0, 24'h7FFFFF, 24'h000001, 0, pulses, valids, done, to_end);
        checkOutput("t2_pulses26", 64'(pulses), 64'd26);
        checkOutput("t2_raw26", 64'(raw_v[0]), 64'h0000_000001_7FFFFF);
        checkOutput("t2_valids", 64'(valids), 64'd1);

        // Tare, then offset measurement
        gain_v[0] = 2'd0;
        @(negedge clk) tare_v[0] = 1'b1;
        @(negedge clk) tare_v[0] = 1'b0;
        applyStimulus(0, 24'd1000, 24'd500, 0, pulses, valids, done, to_end);
        checkOutput("t4_net_tared", net_v[0], 64'd0);
        checkOutput("t4_scaled_tared", scl_v[0], 64'd0);
        applyStimulus(0, 24'd1010, 24'd480, 0, pulses, valids, done, to_end);
        checkOutput("t4_net", net_v[0], 64'hFFFFFFEC_0000000A);
        checkOutput("t4_scaled", scl_v[0], 64'hFFFFF27C_000006C2);

        // No-data timeout
        waitCycles(900);
        checkOutput("t5_timeout_early", 64'(to_v[0]), 64'd0);
        waitCycles(200);
        checkOutput("t5_timeout_set", 64'(to_v[0]), 64'd1);
        checkOutput("t5_pd_low", 64'(pd_v[0]), 64'd0);
        dout_v[0] = 2'b10;
        busy_cnt  = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy_v[0] || pd_v[0]) busy_cnt++;
        end
        checkOutput("t5_partial_ready", 64'(busy_cnt), 64'd0);
        checkOutput("t5_timeout_held", 64'(to_v[0]), 64'd1);
        applyStimulus(0, 24'd5, 24'd6, 0, pulses, valids, done, to_end);
        checkOutput("t5_valids", 64'(valids), 64'd1);
        checkOutput("t5_timeout_clr", 64'(to_end), 64'd0);

        // Averaging with arithmetic shift
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1, avg_ch0[s], avg_ch1[s], 0, pulses, valids, done, to_end);
            checkOutput($sformatf("t3_valid_%0d", s), 64'(valids), (s == 3) ? 64'd1 : 64'd0);
        end
        checkOutput("t3_raw", 64'(raw_v[1]), 64'h0000_FFFFFC_00006A);
        checkOutput("t3_net", net_v[1], 64'hFFFFFFFC_00000067);
        checkOutput("t3_scaled", scl_v[1], 64'hFFFFFD4C_0000459B);

        // Power-down mid-conversion discards partial averages
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1, 24'd7, 24'd7, 0, pulses, valids, done, to_end);
        end
        gain_v[1] = 2'd2;
        applyStimulus(1, 24'd9, 24'd9, 1, pulses, valids, done, to_end);
        @(negedge clk);
        checkOutput("t6_pd_next", 64'(pd_v[1]), 64'd1);
        bad_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (!pd_v[1] || sv_v[1] || busy_v[1]) bad_cnt++;
        end
        checkOutput("t6_pd_held", 64'(bad_cnt), 64'd0);
        pwr_v[1] = 1'b0;
        waitCycles(2);
        checkOutput("t6_wake_pd", 64'(pd_v[1]), 64'd0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1, 24'd20, 24'hFFFFEC, 0, pulses, valids, done, to_end);
            checkOutput($sformatf("t6_pulses_%0d", s), 64'(pulses), (s == 0) ? 64'd25 : 64'd27);
            checkOutput($sformatf("t6_valid_%0d", s), 64'(valids), (s == 3) ? 64'd1 : 64'd0);
        end
        checkOutput("t6_net", net_v[1], 64'hFFFFFFEC_00000014);

        // Reset mid-conversion
        applyStimulus(0, 24'h0000FF, 24'h0000FF, 2, pulses, valids, done, to_end);
        @(negedge clk);
        checkOutput("t6r_pd", 64'(pd_v[0]), 64'd0);
        checkOutput("t6r_raw", 64'(raw_v[0]), 64'd0);
        checkOutput("t6r_net", net_v[0], 64'd0);
        checkOutput("t6r_scaled", scl_v[0], 64'd0);
        checkOutput("t6r_flags", {61'd0, sv_v[0], busy_v[0], to_v[0]}, 64'd0);
        rst_n = 1'b1;
        waitCycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
